// File: rtl/div_result_display.sv
// div_result_display
//   Captures the restoring divider's quotient and remainder when it pulses
//   result_valid. It converts each value to two BCD digits with a sequential
//   double-dabble engine, then scans them onto a 4-digit multiplexed
//   7-segment display. The quotient goes on digits 3:2 and the remainder on
//   digits 1:0.
//
//   Parameters
//     WIDTH        operand width, 1..6 (values up to 63)
//     REFRESH_DIV  cycles each digit is held before the scan advances, >= 2
//
//   Ports
//     clk           system clock, rising edge
//     rst_n         asynchronous active-low reset
//     result_valid  one-cycle capture pulse from the divider
//     quotient      divider quotient  [WIDTH-1:0]
//     remainder     divider remainder [WIDTH-1:0]
//     busy          conversion in progress
//     valid         digits hold a completed result (sticky until reset)
//     seg           {g,f,e,d,c,b,a}, active-low
//     an            digit anodes, active-low; an[0] = remainder ones
//
//   Optional: define DIV_DISP_BLANK_LEADING_ZERO_EN to blank a zero tens
//   digit (digits 3 and 1). The anode stays enabled, so scan timing does
//   not change.
module div_result_display #(
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             result_valid,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             valid,
  output logic [6:0]       seg,
  output logic [3:0]       an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

  // One double-dabble step: bias nibbles >= 5, then shift in the next bit.
  function automatic logic [7:0] dd_step(input logic [7:0] acc, input logic b);
    logic [3:0] hi, lo;
    hi = acc[7:4];
    lo = acc[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi[2:0], lo, b};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  state_t           r_state;
  logic             r_busy, r_valid;
  logic [WIDTH-1:0] r_bin_q, r_bin_r;
  logic [7:0]       r_bcd_q, r_bcd_r;
  logic [IW-1:0]    r_iter;
  logic [3:0][3:0]  r_dig;        // [3]=q tens [2]=q ones [1]=r tens [0]=r ones
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_idx;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;

  logic [7:0]       w_bcd_q_nxt, w_bcd_r_nxt;
  logic             w_last;
  logic [3:0]       w_dig;
  logic [6:0]       w_seg;

  assign w_bcd_q_nxt = dd_step(r_bcd_q, r_bin_q[WIDTH-1]);
  assign w_bcd_r_nxt = dd_step(r_bcd_r, r_bin_r[WIDTH-1]);
  assign w_last      = (r_iter == IW'(WIDTH - 1));

  // Conversion FSM. A capture pulse always wins, so a pulse during CONVERT
  // restarts the conversion with the newest operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_bin_q <= '0;
      r_bin_r <= '0;
      r_bcd_q <= '0;
      r_bcd_r <= '0;
      r_iter  <= '0;
      r_dig   <= '0;
    end else if (result_valid) begin
      r_state <= CONVERT;
      r_busy  <= 1'b1;
      r_bin_q <= quotient;
      r_bin_r <= remainder;
      r_bcd_q <= '0;
      r_bcd_r <= '0;
      r_iter  <= '0;
    end else begin
      case (r_state)
        CONVERT: begin
          r_bcd_q <= w_bcd_q_nxt;
          r_bcd_r <= w_bcd_r_nxt;
          r_bin_q <= r_bin_q << 1;
          r_bin_r <= r_bin_r << 1;
          r_iter  <= r_iter + 1'b1;
          // The displayed digits change only here, so the old result keeps
          // scanning cleanly for the whole conversion.
          if (w_last) begin
            r_dig   <= {w_bcd_q_nxt, w_bcd_r_nxt};
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= SHOW;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_dig = r_dig[r_idx];

  always_comb begin
    w_seg = seg7(w_dig);
`ifdef DIV_DISP_BLANK_LEADING_ZERO_EN
    // Odd indices are the tens slots.
    if (r_idx[0] && (w_dig == 4'd0)) w_seg = 7'h7F;
`endif
  end

  // Scan and registered segment/anode drive. The display runs whenever a
  // result has landed, including while a newer one is being converted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_seg <= 7'h7F;
      r_an  <= 4'hF;
    end else if (r_valid) begin
      if (r_cnt == CW'(REFRESH_DIV - 1)) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg;
    end else begin
      r_seg <= 7'h7F;
      r_an  <= 4'hF;
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign seg   = r_seg;
  assign an    = r_an;

endmodule

// File: tb/tb_div_result_display.sv
// Bench for div_result_display: directed cases plus randomized results,
// checked against an arithmetic model (value/10, value%10, segment table).
module tb_div_result_display;

  localparam int WIDTH = 4;
  localparam int RD    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             result_valid = 1'b0;
  logic [WIDTH-1:0] quotient = '0;
  logic [WIDTH-1:0] remainder = '0;
  logic             busy, valid;
  logic [6:0]       seg;
  logic [3:0]       an;

  div_result_display #(.WIDTH(WIDTH), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .result_valid(result_valid),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .valid(valid), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of what the display should show: digits and whether a result has landed.
  int md[4];
  bit mvalid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int d, input int idx);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef DIV_DISP_BLANK_LEADING_ZERO_EN
    if ((idx == 1 || idx == 3) && d == 0) return 7'h7F;
`endif
    if (idx < 0) return 7'h7F;
    return (d >= 0 && d <= 9) ? t[d] : 7'h7F;
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'hE: return 0;
      4'hD: return 1;
      4'hB: return 2;
      4'h7: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk_disp(input string tag);
    int idx;
    if (!mvalid) begin
      chk({tag, "_an_blank"}, an, 4'hF);
      chk({tag, "_seg_blank"}, seg, 7'h7F);
    end else begin
      idx = an_idx(an);
      chk({tag, "_an_onehot"}, (idx >= 0), 1);
      if (idx >= 0) chk({tag, "_seg"}, seg, exp_seg(md[idx], idx));
    end
  endtask

  task automatic send(input int q, input int r);
    @(negedge clk);
    result_valid = 1'b1;
    quotient     = WIDTH'(q);
    remainder    = WIDTH'(r);
    @(posedge clk);
    #1;
    result_valid = 1'b0;
  endtask

  // Pulse a result, check busy for WIDTH cycles with the old display intact,
  // then valid, then switch the model to the new digits.
  task automatic conv(input int q, input int r, input string tag);
    send(q, r);
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_valid_hold"}, valid, mvalid);
      chk_disp({tag, "_old"});
    end
    @(negedge clk);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_valid_done"}, valid, 1'b1);
    chk_disp({tag, "_edge"});
    md[3] = q / 10; md[2] = q % 10; md[1] = r / 10; md[0] = r % 10;
    mvalid = 1'b1;
  endtask

  // Follow the scan for one full rotation plus one slot: each digit held RD
  // cycles, order 0,1,2,3,0, and each slot shows the model digit.
  task automatic scan_check(input string tag);
    logic [3:0] a0;
    int cnt;
    @(negedge clk);
    a0 = an;
    for (int t = 0; t < RD + 2 && an == a0; t++) @(negedge clk);
    chk({tag, "_sync"}, (an != a0), 1);
    for (int s = 0; s < 5; s++) begin
      a0 = an;
      cnt = 0;
      while (an == a0 && cnt < RD + 2) begin
        chk_disp(tag);
        cnt++;
        @(negedge clk);
      end
      chk({tag, "_hold"}, cnt, RD);
      chk({tag, "_order"}, an_idx(an), (an_idx(a0) + 1) % 4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int q, r;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 4'hF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_disp("idle");

    conv(3, 1, "basic");
    scan_check("basic_scan");

    conv(15, 0, "twodig");
    scan_check("twodig_scan");

    // Restart: second pulse two cycles into the first conversion.
    send(9, 7);
    @(negedge clk);
    chk("restart_busy0", busy, 1'b1);
    chk_disp("restart_old0");
    conv(2, 3, "restart");
    scan_check("restart_scan");

    conv(5, 2, "blank");
    scan_check("blank_scan");

    // Asynchronous reset between clock edges in the middle of a conversion.
    send(7, 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_an", an, 4'hF);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", valid, 1'b0);
    mvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_disp("postrst");
    conv(12, 6, "postrst");
    scan_check("postrst_scan");

    for (int i = 0; i < 12; i++) begin
      q = $urandom_range(15, 0);
      r = $urandom_range(15, 0);
      if ($urandom_range(2, 0) == 0) begin
        send($urandom_range(15, 0), $urandom_range(15, 0));
        repeat ($urandom_range(WIDTH - 1, 0)) @(negedge clk);
      end
      conv(q, r, "rand");
      if ($urandom_range(1, 0) == 1) scan_check("rand_scan");
      else repeat ($urandom_range(6, 0)) begin
        @(negedge clk);
        chk_disp("rand_idle");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
